// File: rtl/serial_alu_if.sv
// Request/response bundle for the bit-serial ALU.
// master: the requester that drives operands.
// slave: the ALU that returns registered results and flags.
interface serial_alu_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/serial_alu.sv
// Bit-serial ALU. Operands are captured in parallel, then streamed LSB-first
// through one full-adder/logic slice per clock. A carry flop links successive
// bits. The assembled word and its flags are published together with a
// one-cycle done pulse.
module serial_alu #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  serial_alu_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  // One-bit slice. Returns {carry_out, bit_out}.
  // Subtraction is a + ~b + 1: b is inverted here, and the +1 comes from the
  // carry flop being preset at capture. Logic ops force the carry to 0.
  function automatic logic [1:0] bit_slice(input logic [1:0] op,
                                           input logic       a_bit,
                                           input logic       b_bit,
                                           input logic       c_in);
    logic b_eff;
    logic [1:0] res;
    b_eff = (op == OP_SUB) ? ~b_bit : b_bit;
    res   = 2'b00;
    case (op)
      OP_ADD, OP_SUB: begin
        res[0] = a_bit ^ b_eff ^ c_in;
        res[1] = (a_bit & b_eff) | (a_bit & c_in) | (b_eff & c_in);
      end
      OP_AND:  res = {1'b0, a_bit & b_eff};
      OP_XOR:  res = {1'b0, a_bit ^ b_eff};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               carry_q,  carry_d;
  logic [1:0]         op_q,     op_d;
  logic [WIDTH-1:0]   a_sr_q,   a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,   b_sr_d;
  logic [WIDTH-2:0]   r_sr_q,   r_sr_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q,   cout_d;
  logic               ovf_q,    ovf_d;
  logic               zero_q,   zero_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;

  logic [1:0]         slice;
  logic [WIDTH-1:0]   word;
  logic               is_arith;

  // Next-state, datapath shift and result publication.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    r_sr_d   = r_sr_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    slice    = bit_slice(op_q, a_sr_q[0], b_sr_q[0], carry_q);
    word     = {slice[0], r_sr_q};
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          op_d    = bus.op;
          carry_d = (bus.op == OP_SUB);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy_d  = 1'b1;
        r_sr_d  = word[WIDTH-1:1];
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d = slice[1];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // The slice is now at the MSB. Overflow is its carry-in XOR carry-out.
          cnt_d    = '0;
          state_d  = S_DONE;
          result_d = word;
          cout_d   = is_arith & slice[1];
          ovf_d    = is_arith & (carry_q ^ slice[1]);
          zero_d   = (word == '0);
          done_d   = 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, shift registers and published outputs.
  // Reset clears everything and drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= 2'b00;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      r_sr_q   <= r_sr_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu. Expected results are pushed to a queue when an
// operation is issued and popped by a monitor when done pulses.
module tb_serial_alu;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   done_cnt;
  logic [W+2:0] last_pub;
  logic done_prev;
  exp_t exp_q[$];

  serial_alu_if #(.WIDTH(W)) bus ();

  serial_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    logic [W:0] s;
    exp_t e;
    e = '0;
    s = '0;
    case (op)
      2'b00: begin
        s   = {1'b0, a} + {1'b0, b};
        e.c = s[W];
        e.v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      2'b01: begin
        s   = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        e.c = s[W];
        e.v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
      end
      2'b10: s = {1'b0, a & b};
      default: s = {1'b0, a ^ b};
    endcase
    e.r = s[W-1:0];
    e.z = (s[W-1:0] == '0);
    return e;
  endfunction

  // Scoreboard monitor: compare on done, check pulse width and output hold.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      done_cnt = done_cnt + 1;
      chk("done_one_cycle", 32'(done_prev), 32'(0));
      chk("busy_in_done", 32'(bus.busy), 32'(1));
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("result", 32'(bus.result), 32'(e.r));
        chk("cout", 32'(bus.cout), 32'(e.c));
        chk("ovf", 32'(bus.ovf), 32'(e.v));
        chk("zero", 32'(bus.zero), 32'(e.z));
      end
      last_pub = {bus.cout, bus.ovf, bus.zero, bus.result};
    end else if (bus.busy === 1'b1) begin
      chk("hold_outputs", 32'({bus.cout, bus.ovf, bus.zero, bus.result}), 32'(last_pub));
    end
    done_prev = bus.done;
  end

  task automatic wait_done(input int target);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= target) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n0;
    @(negedge clk);
    n0        = done_cnt;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 4'($urandom);
    bus.b     = 4'($urandom);
    bus.op    = 2'($urandom);
    wait_done(n0 + 1);
  endtask

  initial begin
    int n0;
    checks    = 0;
    failures  = 0;
    done_cnt  = 0;
    done_prev = 1'b0;
    last_pub  = '0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_outs", 32'({bus.cout, bus.ovf, bus.zero, bus.result}), 32'(0));
    reset = 1'b0;

    // First ADD with cycle-accurate latency and busy window.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 4'b0111;
    bus.b     = 4'b0001;
    exp_q.push_back(model(2'b00, 4'b0111, 4'b0001));
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) bus.start = 1'b0;
      #1;
      chk($sformatf("lat_busy_e%0d", k), 32'(bus.busy), 32'(k <= 4));
      chk($sformatf("lat_done_e%0d", k), 32'(bus.done), 32'(k == 4));
    end

    do_op(2'b00, 4'b1111, 4'b0001);
    do_op(2'b01, 4'b0011, 4'b0101);
    do_op(2'b01, 4'b0101, 4'b0101);
    do_op(2'b10, 4'b1100, 4'b1010);
    do_op(2'b11, 4'b1100, 4'b1010);
    do_op(2'b01, 4'b1000, 4'b0001);
    do_op(2'b00, 4'b1000, 4'b1000);

    // Hold start high and scramble inputs while the first operation runs.
    @(negedge clk);
    n0        = done_cnt;
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 4'b0101;
    bus.b     = 4'b0110;
    exp_q.push_back(model(2'b00, 4'b0101, 4'b0110));
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      bus.a  = 4'($urandom);
      bus.b  = 4'($urandom);
      bus.op = 2'($urandom);
    end
    @(negedge clk);
    #1;
    chk("hold_idle_gap", 32'(bus.busy), 32'(0));
    bus.op = 2'b11;
    bus.a  = 4'b0011;
    bus.b  = 4'b0100;
    exp_q.push_back(model(2'b11, 4'b0011, 4'b0100));
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("hold_second_capture", 32'(bus.busy), 32'(1));
    wait_done(n0 + 2);

    // Reset in the middle of an ADD: no done, all outputs cleared.
    do_op(2'b11, 4'b1100, 4'b1010);
    @(negedge clk);
    n0        = done_cnt;
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = 4'b0111;
    bus.b     = 4'b0101;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'(0));
    chk("midrst_done", 32'(bus.done), 32'(0));
    chk("midrst_outs", 32'({bus.cout, bus.ovf, bus.zero, bus.result}), 32'(0));
    reset    = 1'b0;
    last_pub = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("midrst_no_done", 32'(bus.done), 32'(0));
    end
    chk("midrst_done_cnt", 32'(done_cnt), 32'(n0));
    do_op(2'b00, 4'b0010, 4'b0011);

    // Random back-to-back operations.
    for (int i = 0; i < 12; i++) begin
      do_op(2'($urandom), 4'($urandom), 4'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
